// File: rtl/pkt_arb_mux.sv
// pkt_arb_mux: packet-aware N:1 mux that sits behind a round-robin arbiter.
// It drives the arbiter request/enable lines, locks onto the granted port for
// a whole packet, and registers the winning beats through a 2-entry output
// FIFO (head register plus one skid entry) onto a single valid/ready link.

// Per-port ready decode: a port is accepted only when it is the current source.
module pkt_arb_mux_port #(
  parameter int IW  = 1,
  parameter int IDX = 0
) (
  input  logic          en,
  input  logic [IW-1:0] cur_idx,
  output logic          ready
);
  assign ready = en && (cur_idx == IW'(IDX));
endmodule

module pkt_arb_mux #(
  parameter  int N         = 2,
  parameter  int W         = 64,
  parameter  int MAX_BEATS = 16,
  localparam int IW        = (N > 1) ? $clog2(N) : 1,
  localparam int CW        = $clog2(MAX_BEATS + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   in_valid,
  input  logic [N*W-1:0] in_data,
  input  logic [N-1:0]   in_last,
  output logic [N-1:0]   in_ready,
  output logic [N-1:0]   arb_req,
  output logic           arb_enable,
  input  logic [N-1:0]   arb_gnt,
  output logic           out_valid,
  output logic [W-1:0]   out_data,
  output logic           out_last,
  output logic [IW-1:0]  out_src,
  input  logic           out_ready,
  output logic           err_overlen
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state, state_nxt;
  logic [IW-1:0] sel, gnt_idx, cur_idx;
  logic          gnt_any;
  logic [CW-1:0] beat_cnt, cnt_base;
  logic          acc_en, push, push_last, force_end;
  logic [W-1:0]  push_data;
  logic          fifo_full, pop;
  logic          sk_valid, sk_last;
  logic [W-1:0]  sk_data;
  logic [IW-1:0] sk_src;

  assign arb_req = in_valid;
  assign gnt_any = |arb_gnt;

  // Grant decode: lowest set bit wins if the arbiter ever gives more than one.
  always_comb begin
    gnt_idx = '0;
    for (int i = N - 1; i >= 0; i--)
      if (arb_gnt[i]) gnt_idx = IW'(i);
  end

  // Source selection, accept gating and next state. In IDLE the granted port
  // is taken in the same cycle so a new packet starts with no bubble.
  always_comb begin
    state_nxt  = state;
    cur_idx    = sel;
    cnt_base   = beat_cnt;
    acc_en     = 1'b0;
    arb_enable = 1'b0;
    unique case (state)
      IDLE: begin
        arb_enable = !fifo_full;
        cur_idx    = gnt_idx;
        cnt_base   = '0;
        acc_en     = gnt_any && in_valid[gnt_idx] && !fifo_full;
      end
      BUSY:    acc_en = !fifo_full;
      default: ;
    endcase
    // A beat accepted while reset is high would be lost, so accept nothing.
    if (rst) acc_en = 1'b0;
    push      = acc_en && in_valid[cur_idx];
    push_data = in_data[cur_idx*W +: W];
    // Beat number MAX_BEATS without a last flag closes the packet by force.
    force_end = !in_last[cur_idx] && (cnt_base == CW'(MAX_BEATS - 1));
    push_last = in_last[cur_idx] || force_end;
    if (push) state_nxt = push_last ? IDLE : BUSY;
  end

  for (genvar i = 0; i < N; i++) begin : g_port
    pkt_arb_mux_port #(.IW(IW), .IDX(i)) u_port (
      .en      (acc_en),
      .cur_idx (cur_idx),
      .ready   (in_ready[i])
    );
  end

  // Packet FSM state, held source and saturating beat counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      sel         <= '0;
      beat_cnt    <= '0;
      err_overlen <= 1'b0;
    end else begin
      state       <= state_nxt;
      err_overlen <= push && force_end;
      if (push) begin
        sel      <= cur_idx;
        beat_cnt <= (cnt_base >= CW'(MAX_BEATS)) ? cnt_base : cnt_base + 1'b1;
      end
    end
  end

  assign fifo_full = out_valid && sk_valid;
  assign pop       = out_valid && out_ready;

  // Output FIFO: the head register drives out_* directly, the skid entry
  // absorbs one beat while downstream stalls; out_* hold while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_src   <= '0;
      sk_valid  <= 1'b0;
      sk_data   <= '0;
      sk_last   <= 1'b0;
      sk_src    <= '0;
    end else if (pop || !out_valid) begin
      if (sk_valid) begin
        out_valid <= 1'b1;
        out_data  <= sk_data;
        out_last  <= sk_last;
        out_src   <= sk_src;
        sk_valid  <= push;
        if (push) begin
          sk_data <= push_data;
          sk_last <= push_last;
          sk_src  <= cur_idx;
        end
      end else begin
        out_valid <= push;
        if (push) begin
          out_data <= push_data;
          out_last <= push_last;
          out_src  <= cur_idx;
        end
      end
    end else if (push) begin
      sk_valid <= 1'b1;
      sk_data  <= push_data;
      sk_last  <= push_last;
      sk_src   <= cur_idx;
    end
  end

  // Arbiter grants are expected one-hot; report anything else seen in IDLE.
  always_ff @(posedge clk) begin
    if (!rst && state == IDLE && gnt_any)
      assert ($onehot(arb_gnt))
      else $warning("pkt_arb_mux: arb_gnt %b not one-hot, lowest bit taken", arb_gnt);
  end

endmodule
